// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state enum, BCD type, limits and BCD helpers for the stopwatch controller
package stopwatch_pkg;
  typedef enum logic [1:0] {IDLE, RUN, STOP, LAP} sw_state_t;
  typedef logic [7:0] bcd2_t;
  localparam int CS_MAX = 99;
  localparam int SEC_MAX = 59;
  function automatic bcd2_t to_bcd(input int v);
    return bcd2_t'(((v / 10) << 4) | (v % 10));
  endfunction
  function automatic bcd2_t bcd_inc(input bcd2_t v);
    return v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: button pulses into the controller, time display and status out of it
interface stopwatch_ctrl_if;
  import stopwatch_pkg::*;
  logic start_stop, lap_clr, running, tick, lap_hold, wrap;
  bcd2_t cs, sec, min;
  modport master(output start_stop, lap_clr, input running, tick, cs, sec, min, lap_hold, wrap);
  modport slave(input start_stop, lap_clr, output running, tick, cs, sec, min, lap_hold, wrap);
endinterface

// File: rtl/tick_prescaler.sv
// tick_prescaler: counts 0..DIV-1 while enabled and registers a one-cycle tick on each wrap
module tick_prescaler #(
  parameter int DIV = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  logic last;
  assign last = cnt == W'(DIV - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      tick <= 1'b0;
    end else begin
      cnt <= (clr || (en && last)) ? '0 : cnt + W'(en);
      tick <= !clr && en && last;
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: start/stop/lap/clear FSM with BCD min:sec.cs counters on a centisecond enable.
// Optional LAP freeze and snapshot registers are built only when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIV = 500000,
  parameter int MAX_MIN = 59
) (
  input logic clk,
  input logic reset,
  stopwatch_ctrl_if.slave bus
);
  sw_state_t state, next;
  bcd2_t l_cs, l_sec, l_min, v_cs, v_sec, v_min;
  logic run, tick, clr, lap_go, full_cs, full_sec, full_min;
  assign run = state == RUN || state == LAP;
  tick_prescaler #(.DIV(DIV)) u_pre (.clk(clk), .reset(reset), .en(run), .clr(clr), .tick(tick));
  // Registers hold the pre-tick time; the visible value adds the pending tick so it appears with tick
  assign full_cs = l_cs == to_bcd(CS_MAX);
  assign full_sec = l_sec == to_bcd(SEC_MAX);
  assign full_min = l_min == to_bcd(MAX_MIN);
  always_comb begin
    v_cs = !tick ? l_cs : full_cs ? '0 : bcd_inc(l_cs);
    v_sec = !(tick && full_cs) ? l_sec : full_sec ? '0 : bcd_inc(l_sec);
    v_min = !(tick && full_cs && full_sec) ? l_min : full_min ? '0 : bcd_inc(l_min);
  end
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_ON = 1'b1;
  bcd2_t s_cs, s_sec, s_min;
  always_ff @(posedge clk or negedge reset)
    if (!reset) {s_cs, s_sec, s_min} <= '0;
    else if (lap_go) {s_cs, s_sec, s_min} <= {v_cs, v_sec, v_min};
  assign bus.lap_hold = state == LAP;
  assign bus.cs = bus.lap_hold ? s_cs : v_cs;
  assign bus.sec = bus.lap_hold ? s_sec : v_sec;
  assign bus.min = bus.lap_hold ? s_min : v_min;
`else
  localparam bit LAP_ON = 1'b0;
  assign bus.lap_hold = 1'b0;
  assign bus.cs = v_cs;
  assign bus.sec = v_sec;
  assign bus.min = v_min;
`endif
  always_comb begin
    clr = state == STOP && bus.lap_clr && !bus.start_stop;
    lap_go = LAP_ON && state == RUN && bus.lap_clr && !bus.start_stop;
    next = state;
    case (state)
      IDLE: next = bus.start_stop ? RUN : IDLE;
      RUN: next = bus.start_stop ? STOP : lap_go ? LAP : RUN;
      LAP: next = bus.start_stop ? STOP : bus.lap_clr ? RUN : LAP;
      STOP: next = bus.start_stop ? RUN : clr ? IDLE : STOP;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      {l_cs, l_sec, l_min} <= '0;
    end else begin
      state <= next;
      {l_cs, l_sec, l_min} <= clr ? '0 : {v_cs, v_sec, v_min};
    end
  assign bus.running = run;
  assign bus.tick = tick;
  assign bus.wrap = tick && full_cs && full_sec && full_min;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench; a time-in-centiseconds model predicts every cycle's outputs
module tb_stopwatch_ctrl;
  localparam int DIV = 3;
  localparam int MAX_MIN = 1;
  localparam int PERIOD = (MAX_MIN + 1) * 6000;
  localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2, M_LAP = 3;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_ON = 1'b1;
`else
  localparam bit LAP_ON = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  stopwatch_ctrl_if bus();
  stopwatch_ctrl #(.DIV(DIV), .MAX_MIN(MAX_MIN)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  logic [27:0] q[$];
  logic [27:0] mon_e;
  int tests = 0, fails = 0;
  int m_mode, m_t, m_p, m_snap, m_wraps, dut_wraps;

  function automatic logic [7:0] bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic logic [27:0] pack_dut();
    return {bus.running, bus.tick, bus.lap_hold, bus.wrap, bus.min, bus.sec, bus.cs};
  endfunction

  task automatic check(input string name, input logic [27:0] got, input logic [27:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h (flags run,tick,hold,wrap | min sec cs)", name, got, want);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE;
    m_t = 0;
    m_p = 0;
    m_snap = 0;
  endtask

  // Drive one clock of button inputs and queue the outputs expected after that edge
  task automatic cycle(input bit ss, input bit lc);
    bit cnt_on, tk;
    int disp;
    @(negedge clk);
    bus.start_stop = ss;
    bus.lap_clr = lc;
    cnt_on = m_mode == M_RUN || m_mode == M_LAP;
    tk = cnt_on && m_p == DIV - 1;
    if (cnt_on) m_p = (m_p + 1) % DIV;
    if (m_mode == M_RUN && lc && !ss && LAP_ON) m_snap = m_t;
    if (tk) m_t = (m_t + 1) % PERIOD;
    case (m_mode)
      M_IDLE: if (ss) m_mode = M_RUN;
      M_RUN: if (ss) m_mode = M_STOP; else if (lc && LAP_ON) m_mode = M_LAP;
      M_LAP: if (ss) m_mode = M_STOP; else if (lc) m_mode = M_RUN;
      default: if (ss) m_mode = M_RUN; else if (lc) begin m_mode = M_IDLE; m_t = 0; m_p = 0; end
    endcase
    if (tk && m_t == 0) m_wraps++;
    disp = m_mode == M_LAP ? m_snap : m_t;
    q.push_back({m_mode == M_RUN || m_mode == M_LAP, tk, m_mode == M_LAP, tk && m_t == 0,
                 bcd(disp / 6000), bcd((disp / 100) % 60), bcd(disp % 100)});
  endtask

  task automatic run_to(input int target);
    int n = 0;
    while (m_t != target && n < PERIOD * DIV + 10) begin
      cycle(0, 0);
      n++;
    end
    if (m_t != target) begin
      tests++;
      fails++;
      $display("FAIL run_to: model time %0d never reached %0d", m_t, target);
    end
  endtask

  task automatic to_run();
    int n = 0;
    while (m_mode != M_RUN && n < 8) begin
      cycle(m_mode == M_IDLE || m_mode == M_STOP, m_mode == M_LAP);
      n++;
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      if (bus.wrap) dut_wraps++;
      check("cycle", pack_dut(), mon_e);
    end
  end

  initial begin
    bus.start_stop = 1'b0;
    bus.lap_clr = 1'b0;
    m_wraps = 0;
    dut_wraps = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 check("reset_state", pack_dut(), 28'h0);
    @(negedge clk) reset = 1'b1;
    repeat (2) cycle(0, 0);
    cycle(0, 1);
    cycle(1, 0);
    run_to(7);
    cycle(1, 0);
    repeat (20) cycle(0, 0);
    cycle(1, 1);
    run_to(99);
    repeat (2 * DIV) cycle(0, 0);
    run_to(5999);
    repeat (2 * DIV) cycle(0, 0);
    run_to(6005);
    cycle(0, 1);
    repeat (10 * DIV) cycle(0, 0);
    cycle(0, 1);
    repeat (2 * DIV) cycle(0, 0);
    cycle(0, 1);
    repeat (DIV) cycle(0, 0);
    cycle(1, 0);
    cycle(0, 1);
    repeat (3) cycle(0, 0);
    cycle(1, 0);
    for (int i = 0; i < DIV && m_p != DIV - 1; i++) cycle(0, 0);
    cycle(1, 0);
    repeat (5) cycle(0, 0);
    cycle(1, 0);
    run_to(PERIOD - 1);
    repeat (3 * DIV) cycle(0, 0);
    for (int i = 0; i < 3000; i++) begin
      automatic int r = $urandom_range(0, 15);
      cycle(r == 0 || r == 2, r == 1 || r == 2);
    end
    to_run();
    repeat (5 * DIV) cycle(0, 0);
    cycle(0, 1);
    repeat (4) cycle(0, 0);
    @(posedge clk);
    #3;
    bus.start_stop = 1'b0;
    bus.lap_clr = 1'b0;
    reset = 1'b0;
    #1 check("async_reset", pack_dut(), 28'h0);
    model_reset();
    @(negedge clk) reset = 1'b1;
    cycle(1, 0);
    repeat (3 * DIV + 2) cycle(0, 0);
    @(posedge clk);
    #2;
    check("wrap_count", 28'(dut_wraps), 28'(m_wraps));
    check("wrap_seen", 28'(m_wraps > 0 && dut_wraps > 0), 28'd1);
    check("queue_drained", 28'(q.size()), 28'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
